alu_op_encoder: RTL and testbench

- Decode/execute-boundary stage that encodes RV32I instruction fields into the 4-bit ALU operation code and the operand-select flag.
- Registers the result toward the execute stage through a 2-entry skid buffer with valid/ready handshakes on both sides.
- Flags unsupported encodings and keeps a saturating count of them.

---
 rtl/alu_op_encoder.sv | 202 ++++++++++++++++++++
 tb/tb_alu_op_encoder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_encoder.sv
// alu_op_encoder: RV32I decode/execute boundary stage.
// Encodes opcode/funct3/funct7b5 into an ALU operation code plus operand-select
// flag, flags unsupported encodings, and hands the result to execute through a
// 2-entry skid buffer (main register drives the outputs, skid absorbs one
// extra entry so in_ready can be registered).
// Optional feature macro: ALU_OP_ENC_BRANCH_CMP_EN (branch compare decode).
module alu_op_encoder #(
  parameter int unsigned OPCODE_LENGTH = 4,
  parameter int unsigned ILL_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [6:0]               opcode,
  input  logic [2:0]               funct3,
  input  logic                     funct7b5,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     alu_src_imm,
  output logic                     illegal,
  output logic [ILL_CNT_WIDTH-1:0] ill_count
);

  localparam int unsigned OPW = OPCODE_LENGTH;
  localparam int unsigned CW  = ILL_CNT_WIDTH;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [OPW-1:0] ALU_AND = OPW'(4'b0000);
  localparam logic [OPW-1:0] ALU_XOR = OPW'(4'b0001);
  localparam logic [OPW-1:0] ALU_SUB = OPW'(4'b0010);
  localparam logic [OPW-1:0] ALU_OR  = OPW'(4'b0011);
  localparam logic [OPW-1:0] ALU_ADD = OPW'(4'b0100);
  localparam logic [OPW-1:0] ALU_EQ  = OPW'(4'b1000);
  localparam logic [OPW-1:0] ALU_SLL = OPW'(4'b1001);
  localparam logic [OPW-1:0] ALU_LUI = OPW'(4'b1010);
  localparam logic [OPW-1:0] ALU_SRL = OPW'(4'b1011);
  localparam logic [OPW-1:0] ALU_SLT = OPW'(4'b1110);

  typedef struct packed {
    logic [OPW-1:0] op;
    logic           src_imm;
    logic           ill;
  } entry_t;

  localparam entry_t ENTRY_RST = '{op: '0, src_imm: 1'b0, ill: 1'b0};

  entry_t                r_main;
  entry_t                r_skid;
  logic                  r_main_valid;
  logic                  r_skid_valid;
  logic                  r_in_ready;
  logic [CW-1:0]         r_ill_count;

  entry_t                w_dec;
  entry_t                w_main_nxt;
  entry_t                w_skid_nxt;
  logic                  w_main_valid_nxt;
  logic                  w_skid_valid_nxt;
  logic [CW-1:0]         w_ill_count_nxt;
  logic                  w_accept;
  logic                  w_consume;

  assign w_accept  = in_valid & r_in_ready;
  assign w_consume = r_main_valid & out_ready;

  // Combinational decode of the presented instruction fields.
  always_comb begin
    w_dec = ENTRY_RST;
    unique case (opcode)
      OPC_R: begin
        w_dec.src_imm = 1'b0;
        unique case (funct3)
          3'b000:  w_dec.op = funct7b5 ? ALU_SUB : ALU_ADD;
          3'b111:  w_dec.op = ALU_AND;
          3'b110:  w_dec.op = ALU_OR;
          3'b100:  w_dec.op = ALU_XOR;
          3'b010:  w_dec.op = ALU_SLT;
          3'b001:  w_dec.op = ALU_SLL;
          3'b101: begin
            // SRA is not supported; keep the shift code but flag it.
            w_dec.op  = ALU_SRL;
            w_dec.ill = funct7b5;
          end
          default: w_dec.ill = 1'b1;
        endcase
      end
      OPC_I: begin
        w_dec.src_imm = 1'b1;
        unique case (funct3)
          3'b000:  w_dec.op = ALU_ADD;
          3'b111:  w_dec.op = ALU_AND;
          3'b110:  w_dec.op = ALU_OR;
          3'b100:  w_dec.op = ALU_XOR;
          3'b010:  w_dec.op = ALU_SLT;
          3'b001:  w_dec.op = ALU_SLL;
          3'b101: begin
            // SRAI is not supported; keep the shift code but flag it.
            w_dec.op  = ALU_SRL;
            w_dec.ill = funct7b5;
          end
          default: w_dec.ill = 1'b1;
        endcase
      end
      OPC_LOAD, OPC_STORE: begin
        w_dec.op      = ALU_ADD;
        w_dec.src_imm = 1'b1;
      end
      OPC_LUI: begin
        w_dec.op      = ALU_LUI;
        w_dec.src_imm = 1'b1;
      end
      OPC_BRANCH: begin
        w_dec.src_imm = 1'b0;
`ifdef ALU_OP_ENC_BRANCH_CMP_EN
        unique case (funct3)
          3'b000, 3'b001: w_dec.op = ALU_EQ;
          3'b100, 3'b101: w_dec.op = ALU_SLT;
          default:        w_dec.ill = 1'b1;
        endcase
`else
        w_dec.op = ALU_SUB;
`endif
      end
      default: w_dec.ill = 1'b1;
    endcase
  end

  // Skid-buffer next state: flush wins, otherwise fill main first, spill to skid.
  always_comb begin
    w_main_nxt       = r_main;
    w_skid_nxt       = r_skid;
    w_main_valid_nxt = r_main_valid;
    w_skid_valid_nxt = r_skid_valid;
    if (flush) begin
      w_main_valid_nxt = 1'b0;
      w_skid_valid_nxt = 1'b0;
    end else if (w_consume) begin
      if (r_skid_valid) begin
        // in_ready is low while skid is full, so no accept can collide here.
        w_main_nxt       = r_skid;
        w_skid_valid_nxt = 1'b0;
      end else if (w_accept) begin
        w_main_nxt       = w_dec;
        w_main_valid_nxt = 1'b1;
      end else begin
        w_main_valid_nxt = 1'b0;
      end
    end else if (!r_main_valid) begin
      if (w_accept) begin
        w_main_nxt       = w_dec;
        w_main_valid_nxt = 1'b1;
      end
    end else if (w_accept) begin
      w_skid_nxt       = w_dec;
      w_skid_valid_nxt = 1'b1;
    end
  end

  // Saturating count of accepted illegal entries; flush does not clear it.
  always_comb begin
    w_ill_count_nxt = r_ill_count;
    if (w_accept && w_dec.ill && (r_ill_count != {CW{1'b1}})) begin
      w_ill_count_nxt = r_ill_count + CW'(1);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_main       <= ENTRY_RST;
      r_skid       <= ENTRY_RST;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
      r_ill_count  <= '0;
    end else begin
      r_main       <= w_main_nxt;
      r_skid       <= w_skid_nxt;
      r_main_valid <= w_main_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_in_ready   <= ~w_skid_valid_nxt;
      r_ill_count  <= w_ill_count_nxt;
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_main_valid;
  assign Operation   = r_main.op;
  assign alu_src_imm = r_main.src_imm;
  assign illegal     = r_main.ill;
  assign ill_count   = r_ill_count;

endmodule

// File: tb/tb_alu_op_encoder.sv
// Directed self-checking bench for alu_op_encoder.
// Honours ALU_OP_ENC_BRANCH_CMP_EN for the branch expectation.
`timescale 1ns/1ps
module tb_alu_op_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] Operation;
  logic       alu_src_imm;
  logic       illegal;
  logic [7:0] ill_count;

  int n_vec  = 0;
  int n_fail = 0;

  alu_op_encoder #(.OPCODE_LENGTH(4), .ILL_CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .Operation(Operation),
    .alu_src_imm(alu_src_imm), .illegal(illegal), .ill_count(ill_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [6:0] opc, input logic [2:0] f3, input logic f7);
    in_valid = 1'b1; opcode = opc; funct3 = f3; funct7b5 = f7;
  endtask

  typedef struct {
    logic [6:0] opc; logic [2:0] f3; logic f7;
    logic [3:0] op;  logic src; logic ill;
  } vec_t;

  vec_t tbl [11];

  initial begin
    tbl[0]  = '{7'b0110011, 3'b010, 1'b0, 4'hE, 1'b0, 1'b0}; // SLT
    tbl[1]  = '{7'b0010011, 3'b001, 1'b0, 4'h9, 1'b1, 1'b0}; // SLLI
    tbl[2]  = '{7'b0110011, 3'b101, 1'b0, 4'hB, 1'b0, 1'b0}; // SRL
    tbl[3]  = '{7'b0110011, 3'b101, 1'b1, 4'hB, 1'b0, 1'b1}; // SRA
    tbl[4]  = '{7'b0010011, 3'b100, 1'b1, 4'h1, 1'b1, 1'b0}; // XORI f7 ignored
    tbl[5]  = '{7'b0010011, 3'b011, 1'b0, 4'h0, 1'b1, 1'b1}; // I 011
    tbl[6]  = '{7'b0000011, 3'b010, 1'b0, 4'h4, 1'b1, 1'b0}; // LW
    tbl[7]  = '{7'b0100011, 3'b010, 1'b1, 4'h4, 1'b1, 1'b0}; // SW
    tbl[8]  = '{7'b1101111, 3'b000, 1'b0, 4'h0, 1'b0, 1'b1}; // JAL unsupported
    tbl[9]  = '{7'b0110011, 3'b110, 1'b0, 4'h3, 1'b0, 1'b0}; // OR
    tbl[10] = '{7'b0010011, 3'b000, 1'b1, 4'h4, 1'b1, 1'b0}; // ADDI f7=1

    rst_n = 1'b0; in_valid = 1'b0; opcode = '0; funct3 = '0; funct7b5 = 1'b0;
    flush = 1'b0; out_ready = 1'b0;
    step(); step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_op",        32'(Operation), 32'h0);
    chk("rst_src",       32'(alu_src_imm), 32'd0);
    chk("rst_ill",       32'(illegal),   32'd0);
    chk("rst_cnt",       32'(ill_count), 32'd0);
    rst_n = 1'b1;

    // SUB, one-cycle latency
    out_ready = 1'b1;
    put(7'b0110011, 3'b000, 1'b1);
    step();
    in_valid = 1'b0;
    chk("sub_valid", 32'(out_valid), 32'd1);
    chk("sub_op",    32'(Operation), 32'h2);
    chk("sub_src",   32'(alu_src_imm), 32'd0);
    chk("sub_ill",   32'(illegal),   32'd0);
    step();
    chk("sub_drain", 32'(out_valid), 32'd0);

    // ADDI, ANDI, LUI back-to-back with out_ready low
    out_ready = 1'b0;
    put(7'b0010011, 3'b000, 1'b0);
    step();
    chk("bb_main_op",  32'(Operation), 32'h4);
    chk("bb_main_src", 32'(alu_src_imm), 32'd1);
    chk("bb_rdy1",     32'(in_ready),  32'd1);
    put(7'b0010011, 3'b111, 1'b0);
    step();
    chk("bb_rdy0",     32'(in_ready),  32'd0);
    chk("bb_hold_op",  32'(Operation), 32'h4);
    put(7'b0110111, 3'b000, 1'b0);
    step();
    chk("bb_stall_rdy", 32'(in_ready), 32'd0);
    chk("bb_stall_op",  32'(Operation), 32'h4);
    chk("bb_stall_vld", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    step();
    chk("bb_andi_op",  32'(Operation), 32'h0);
    chk("bb_andi_vld", 32'(out_valid), 32'd1);
    chk("bb_rdy_back", 32'(in_ready),  32'd1);
    step();
    in_valid = 1'b0;
    chk("bb_lui_op",  32'(Operation), 32'hA);
    chk("bb_lui_vld", 32'(out_valid), 32'd1);
    chk("bb_lui_src", 32'(alu_src_imm), 32'd1);
    step();
    chk("bb_empty", 32'(out_valid), 32'd0);

    // Illegal SRAI and counter saturation
    put(7'b0010011, 3'b101, 1'b1);
    step();
    chk("srai_ill", 32'(illegal),   32'd1);
    chk("srai_op",  32'(Operation), 32'hB);
    chk("srai_cnt", 32'(ill_count), 32'd1);
    for (int i = 0; i < 299; i++) step();
    in_valid = 1'b0;
    chk("cnt_sat", 32'(ill_count), 32'd255);
    step();

    // Decode table, one entry at a time
    for (int i = 0; i < 11; i++) begin
      put(tbl[i].opc, tbl[i].f3, tbl[i].f7);
      step();
      in_valid = 1'b0;
      chk($sformatf("tbl%0d_vld", i), 32'(out_valid), 32'd1);
      chk($sformatf("tbl%0d_op", i),  32'(Operation), 32'(tbl[i].op));
      chk($sformatf("tbl%0d_src", i), 32'(alu_src_imm), 32'(tbl[i].src));
      chk($sformatf("tbl%0d_ill", i), 32'(illegal), 32'(tbl[i].ill));
      step();
    end
    chk("cnt_still_sat", 32'(ill_count), 32'd255);

    // Flush with skid full and an incoming entry
    out_ready = 1'b0;
    put(7'b0110011, 3'b000, 1'b0);
    step();
    put(7'b0110011, 3'b100, 1'b0);
    step();
    chk("fl_full_rdy", 32'(in_ready), 32'd0);
    put(7'b0110011, 3'b110, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_vld", 32'(out_valid), 32'd0);
    chk("fl_rdy", 32'(in_ready),  32'd1);
    out_ready = 1'b1;
    step();
    chk("fl_no_ghost1", 32'(out_valid), 32'd0);
    step();
    chk("fl_no_ghost2", 32'(out_valid), 32'd0);

    // Branch funct3=100
    put(7'b1100011, 3'b100, 1'b0);
    step();
    in_valid = 1'b0;
`ifdef ALU_OP_ENC_BRANCH_CMP_EN
    chk("blt_op", 32'(Operation), 32'hE);
`else
    chk("blt_op", 32'(Operation), 32'h2);
`endif
    chk("blt_ill", 32'(illegal),     32'd0);
    chk("blt_src", 32'(alu_src_imm), 32'd0);
    step();

    // Reset with both registers full and ill_count=5
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst2_cnt", 32'(ill_count), 32'd0);
    put(7'b0000000, 3'b000, 1'b0);
    step(); step(); step();
    in_valid = 1'b0;
    chk("cnt3", 32'(ill_count), 32'd3);
    step();
    out_ready = 1'b0;
    put(7'b0110011, 3'b011, 1'b0);
    step(); step();
    in_valid = 1'b0;
    chk("pre_rst_cnt", 32'(ill_count), 32'd5);
    chk("pre_rst_rdy", 32'(in_ready),  32'd0);
    chk("pre_rst_ill", 32'(illegal),   32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst3_vld", 32'(out_valid),   32'd0);
    chk("rst3_rdy", 32'(in_ready),    32'd1);
    chk("rst3_op",  32'(Operation),   32'h0);
    chk("rst3_src", 32'(alu_src_imm), 32'd0);
    chk("rst3_ill", 32'(illegal),     32'd0);
    chk("rst3_cnt", 32'(ill_count),   32'd0);
    out_ready = 1'b1;
    step();
    chk("rst3_no_ghost", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
